lstm_seq_ctrl: RTL and testbench

LSTM_SEQ_CTRL -- requirements
Module: lstm_seq_ctrl

---
 rtl/lstm_pkg.sv | 6 +
 rtl/lstm_watchdog.sv | 18 +
 rtl/lstm_seq_ctrl.sv | 90 +++++++++
 tb/tb_lstm_seq_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lstm_pkg.sv
// lstm_pkg: shared widths, timeout default and controller state encoding
package lstm_pkg;
  localparam int DATA_W = 10;
  localparam int TIMEOUT = 4095;
  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, EMIT, FIN, ERR} state_t;
endpackage

// File: rtl/lstm_watchdog.sv
// lstm_watchdog: counts enabled cycles, flags the LIMIT-th one without clearing
module lstm_watchdog #(
  parameter int LIMIT = 4095
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && !expired) cnt <= cnt + W'(1);
  assign expired = en && (cnt == W'(LIMIT - 1));
endmodule

// File: rtl/lstm_seq_ctrl.sv
// lstm_seq_ctrl: sequences timesteps through an external LSTM unit,
// carrying hidden/cell state from one step to the next
module lstm_seq_ctrl #(
  parameter int DATA_W = lstm_pkg::DATA_W,
  parameter int LEN_W = 9,
  parameter int TIMEOUT = lstm_pkg::TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  seq_len,
  input  logic              x_valid,
  output logic              x_ready,
  input  logic [DATA_W-1:0] x_data,
  output logic              unit_load,
  output logic [DATA_W-1:0] unit_x,
  output logic [DATA_W-1:0] unit_a_prev,
  output logic [DATA_W-1:0] unit_c_prev,
  input  logic              unit_done,
  input  logic [DATA_W-1:0] unit_a_next,
  input  logic [DATA_W-1:0] unit_c_next,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_c,
  output logic              out_last,
  output logic              busy,
  output logic              seq_done,
  output logic              err,
  output logic [LEN_W-1:0]  step
);
  import lstm_pkg::*;
  state_t state, nxt;
  logic [LEN_W-1:0] len;
  logic [DATA_W-1:0] a_reg, c_reg;
  logic expired;
  lstm_watchdog #(.LIMIT(TIMEOUT)) u_wd (
    .clk(clk), .reset(reset), .clr(state == ISSUE), .en(state == WAIT), .expired(expired)
  );
  assign x_ready = state == FETCH;
  assign unit_load = state == ISSUE;
  assign out_valid = state == EMIT;
  assign out_last = (state == EMIT) && (step == len - LEN_W'(1));
  assign busy = state != IDLE;
  assign seq_done = state == FIN;
  assign unit_a_prev = a_reg;
  assign unit_c_prev = c_reg;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = (seq_len == '0) ? FIN : FETCH;
      FETCH:   if (x_valid) nxt = ISSUE;
      ISSUE:   nxt = WAIT;
      WAIT:    nxt = unit_done ? EMIT : expired ? ERR : WAIT;
      EMIT:    if (out_ready) nxt = out_last ? FIN : FETCH;
      FIN:     nxt = IDLE;
      default: nxt = state;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      len <= '0;
      step <= '0;
      a_reg <= '0;
      c_reg <= '0;
      unit_x <= '0;
      out_a <= '0;
      out_c <= '0;
      err <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        len <= seq_len;
        step <= '0;
        a_reg <= '0;
        c_reg <= '0;
      end
      if (state == FETCH && x_valid) unit_x <= x_data;
      if (state == WAIT && unit_done) begin
        a_reg <= unit_a_next;
        c_reg <= unit_c_next;
        out_a <= unit_a_next;
        out_c <= unit_c_next;
      end
      if (state == WAIT && !unit_done && expired) err <= 1'b1;
      if (state == EMIT && out_ready && !out_last) step <= step + LEN_W'(1);
    end
endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// tb_lstm_seq_ctrl: scenario tasks with a unit model and an output scoreboard
module tb_lstm_seq_ctrl;
  logic clk = 0, reset = 0, start = 0, x_valid = 0, out_ready = 0;
  logic [8:0] seq_len = '0;
  logic [9:0] x_data = '0;
  logic x_ready, unit_load, unit_done = 0, out_valid, out_last, busy, seq_done, err;
  logic [9:0] unit_x, unit_a_prev, unit_c_prev, unit_a_next = '0, unit_c_next = '0, out_a, out_c;
  logic [8:0] step;
  int n_chk = 0, n_fail = 0;
  int load_cnt = 0, done_cnt = 0, xr_cnt = 0, pend_cnt = 0;
  bit pend = 0, resp_en = 1, spur = 0;
  logic [9:0] ua, uc, model_a;
  logic [9:0] exp_a[$], exp_c[$];
  bit exp_l[$];

  lstm_seq_ctrl #(.DATA_W(10), .LEN_W(9), .TIMEOUT(20)) dut (
    .clk(clk), .reset(reset), .start(start), .seq_len(seq_len),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
    .unit_load(unit_load), .unit_x(unit_x), .unit_a_prev(unit_a_prev), .unit_c_prev(unit_c_prev),
    .unit_done(unit_done), .unit_a_next(unit_a_next), .unit_c_next(unit_c_next),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_c(out_c),
    .out_last(out_last), .busy(busy), .seq_done(seq_done), .err(err), .step(step)
  );

  always #5 clk = ~clk;

  // LSTM unit stand-in: a_next = x + a_prev, c_next = x, five cycles after unit_load
  always begin
    @(posedge clk); #1;
    if (unit_load) load_cnt++;
    if (seq_done) done_cnt++;
    if (x_ready) xr_cnt++;
    unit_done = 0;
    if (spur) unit_done = 1;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        pend = 0;
        unit_done = 1;
        unit_a_next = ua;
        unit_c_next = uc;
      end
    end
    if (unit_load && resp_en) begin
      pend = 1;
      pend_cnt = 5;
      ua = unit_x + unit_a_prev;
      uc = unit_x;
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic do_start(input logic [8:0] len);
    start = 1; seq_len = len;
    tick();
    start = 0;
  endtask

  task automatic send_x(input logic [9:0] x, output bit ok);
    ok = 0; x_valid = 1; x_data = x;
    for (int i = 0; i < 50 && !ok; i++) begin
      ok = x_ready;
      tick();
    end
    x_valid = 0;
  endtask

  task automatic wait_out(output bit ok);
    ok = out_valid;
    for (int i = 0; i < 100 && !ok; i++) begin
      tick();
      ok = out_valid;
    end
  endtask

  task automatic take();
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask

  task automatic push_x(input logic [9:0] x, input bit last);
    model_a = model_a + x;
    exp_a.push_back(model_a); exp_c.push_back(x); exp_l.push_back(last);
  endtask

  task automatic test_reset();
    tick();
    n_chk++;
    if ({x_ready, unit_load, out_valid, out_last, busy, seq_done, err} !== 7'b0) begin
      n_fail++; $display("FAIL reset_ctrl got %b want 0", {x_ready, unit_load, out_valid, out_last, busy, seq_done, err});
    end
    n_chk++;
    if ({step, unit_x, out_a, out_c, unit_a_prev, unit_c_prev} !== '0) begin
      n_fail++; $display("FAIL reset_data step=%0d ux=%0d oa=%0d oc=%0d want 0", step, unit_x, out_a, out_c);
    end
    reset = 1;
    tick();
  endtask

  task automatic test_basic();
    bit ok;
    int l0 = load_cnt, d0 = done_cnt;
    logic [9:0] ea, ec;
    bit el;
    model_a = 0;
    do_start(3);
    for (int i = 0; i < 3; i++) begin
      send_x(10'(i + 1), ok);
      n_chk++;
      if (!ok) begin n_fail++; $display("FAIL basic_x_accept step %0d got timeout want accept", i); end
      push_x(10'(i + 1), i == 2);
      wait_out(ok);
      n_chk++;
      if (!ok) begin n_fail++; $display("FAIL basic_out_valid step %0d got timeout want out_valid", i); end
      ea = exp_a.pop_front(); ec = exp_c.pop_front(); el = exp_l.pop_front();
      n_chk++;
      if (out_a !== ea || out_c !== ec || out_last !== el || step !== 9'(i)) begin
        n_fail++; $display("FAIL basic_out step %0d got a=%0d c=%0d last=%b step=%0d want a=%0d c=%0d last=%b",
                           i, out_a, out_c, out_last, step, ea, ec, el);
      end
      take();
    end
    tick();
    n_chk++;
    if (done_cnt - d0 != 1 || load_cnt - l0 != 3 || busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_end got done=%0d loads=%0d busy=%b want 1 3 0", done_cnt - d0, load_cnt - l0, busy);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int l0;
    logic [9:0] ea, ec;
    model_a = 0;
    do_start(2);
    send_x(10'd5, ok);
    push_x(10'd5, 0);
    wait_out(ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL bp_out_valid got timeout want out_valid"); end
    l0 = load_cnt;
    ea = exp_a[0]; ec = exp_c[0];
    for (int i = 0; i < 10; i++) begin
      n_chk++;
      if (out_valid !== 1'b1 || out_a !== ea || out_c !== ec || out_last !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold cycle %0d got v=%b a=%0d c=%0d last=%b want 1 %0d %0d 0", i, out_valid, out_a, out_c, out_last, ea, ec);
      end
      tick();
    end
    n_chk++;
    if (load_cnt != l0) begin n_fail++; $display("FAIL bp_no_load got %0d loads want 0", load_cnt - l0); end
    void'(exp_a.pop_front()); void'(exp_c.pop_front()); void'(exp_l.pop_front());
    take();
    send_x(10'h3FD, ok);
    push_x(10'h3FD, 1);
    wait_out(ok);
    ea = exp_a.pop_front(); ec = exp_c.pop_front();
    n_chk++;
    if (!ok || out_a !== ea || out_c !== ec || out_last !== exp_l.pop_front()) begin
      n_fail++; $display("FAIL bp_step1 got a=%0d c=%0d last=%b want a=%0d c=%0d last=1", out_a, out_c, out_last, ea, ec);
    end
    take();
    tick();
  endtask

  task automatic test_zero_len();
    int l0 = load_cnt, x0 = xr_cnt, d0 = done_cnt;
    bit seen = 0;
    do_start(0);
    for (int i = 0; i < 2 && !seen; i++) begin
      seen = done_cnt != d0;
      tick();
    end
    n_chk++;
    if (!seen) begin n_fail++; $display("FAIL zero_done got no seq_done want pulse within 2 cycles"); end
    tick();
    n_chk++;
    if (load_cnt != l0 || xr_cnt != x0 || busy !== 1'b0 || done_cnt - d0 != 1) begin
      n_fail++; $display("FAIL zero_quiet got loads=%0d xr=%0d busy=%b done=%0d want 0 0 0 1", load_cnt - l0, xr_cnt - x0, busy, done_cnt - d0);
    end
  endtask

  task automatic test_spurious();
    bit ok;
    int l0 = load_cnt, d0 = done_cnt;
    logic [9:0] ea;
    model_a = 0;
    do_start(1);
    spur = 1;
    tick();
    spur = 0;
    tick();
    n_chk++;
    if (x_ready !== 1'b1 || out_valid !== 1'b0 || load_cnt != l0) begin
      n_fail++; $display("FAIL spur_fetch got xr=%b ov=%b loads=%0d want 1 0 0", x_ready, out_valid, load_cnt - l0);
    end
    send_x(10'd7, ok);
    push_x(10'd7, 1);
    wait_out(ok);
    start = 1; seq_len = 9'd5;
    tick();
    start = 0;
    tick();
    ea = exp_a.pop_front();
    n_chk++;
    if (out_valid !== 1'b1 || step !== 9'd0 || out_a !== ea || out_c !== exp_c.pop_front() || out_last !== exp_l.pop_front()) begin
      n_fail++; $display("FAIL spur_emit got ov=%b step=%0d a=%0d last=%b want 1 0 %0d 1", out_valid, step, out_a, out_last, ea);
    end
    take();
    tick();
    tick();
    n_chk++;
    if (busy !== 1'b0 || load_cnt - l0 != 1 || done_cnt - d0 != 1) begin
      n_fail++; $display("FAIL spur_end got busy=%b loads=%0d done=%0d want 0 1 1", busy, load_cnt - l0, done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [9:0] ea, ec;
    model_a = 0;
    do_start(3);
    send_x(10'd4, ok);
    wait_out(ok);
    take();
    resp_en = 0;
    send_x(10'd6, ok);
    tick(); tick(); tick();
    reset = 0;
    tick();
    n_chk++;
    if ({x_ready, unit_load, out_valid, out_last, busy, seq_done, err, step, unit_x, out_a, out_c, unit_a_prev, unit_c_prev} !== '0) begin
      n_fail++; $display("FAIL midreset_zero got xr=%b ld=%b ov=%b busy=%b step=%0d ux=%0d oa=%0d ap=%0d want all 0",
                         x_ready, unit_load, out_valid, busy, step, unit_x, out_a, unit_a_prev);
    end
    reset = 1; resp_en = 1;
    tick();
    do_start(2);
    send_x(10'd9, ok);
    push_x(10'd9, 0);
    n_chk++;
    if (unit_load !== 1'b1 || unit_a_prev !== 10'd0 || unit_c_prev !== 10'd0) begin
      n_fail++; $display("FAIL midreset_first_load got ld=%b ap=%0d cp=%0d want 1 0 0", unit_load, unit_a_prev, unit_c_prev);
    end
    for (int i = 0; i < 2; i++) begin
      if (i == 1) begin
        send_x(10'd1, ok);
        push_x(10'd1, 1);
        n_chk++;
        if (unit_load !== 1'b1 || unit_a_prev !== 10'd9 || unit_c_prev !== 10'd9) begin
          n_fail++; $display("FAIL midreset_carry got ld=%b ap=%0d cp=%0d want 1 9 9", unit_load, unit_a_prev, unit_c_prev);
        end
      end
      wait_out(ok);
      ea = exp_a.pop_front(); ec = exp_c.pop_front();
      n_chk++;
      if (!ok || out_a !== ea || out_c !== ec || out_last !== exp_l.pop_front()) begin
        n_fail++; $display("FAIL midreset_out step %0d got a=%0d c=%0d last=%b want a=%0d c=%0d", i, out_a, out_c, out_last, ea, ec);
      end
      take();
    end
    tick();
  endtask

  task automatic test_timeout();
    bit ok;
    int l0;
    resp_en = 0;
    do_start(1);
    send_x(10'd3, ok);
    n_chk++;
    if (unit_load !== 1'b1) begin n_fail++; $display("FAIL to_load got %b want 1", unit_load); end
    l0 = load_cnt;
    for (int i = 0; i < 20; i++) tick();
    n_chk++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL to_early got err=%b want 0 at 20 cycles", err); end
    tick();
    n_chk++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL to_err got err=%b want 1", err); end
    do_start(1);
    tick(); tick();
    n_chk++;
    if (err !== 1'b1 || busy !== 1'b1 || x_ready !== 1'b0 || out_valid !== 1'b0 || unit_load !== 1'b0 || load_cnt != l0) begin
      n_fail++; $display("FAIL to_stuck got err=%b busy=%b xr=%b ov=%b loads=%0d want 1 1 0 0 0", err, busy, x_ready, out_valid, load_cnt - l0);
    end
    reset = 0;
    tick();
    reset = 1; resp_en = 1;
    tick();
    n_chk++;
    if (err !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL to_reset got err=%b busy=%b want 0 0", err, busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_len();
    test_spurious();
    test_reset_mid();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
